apb_wrr_arbiter: RTL

APB_WRR_ARBITER -- requirements
Module: apb_wrr_arbiter

---
 rtl/apb_wrr_arbiter_if.sv | 26 ++
 rtl/apb_wrr_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/apb_wrr_arbiter_if.sv
// Bus-side signals of the APB weighted round-robin arbiter: per-master phase
// inputs, shared slave ready, and the grant/ownership/error outputs.
interface apb_wrr_arbiter_if #(
  parameter int NO_OF_MASTERS = 2,
  parameter int OWNER_W       = (NO_OF_MASTERS > 1) ? $clog2(NO_OF_MASTERS) : 1
);
  logic [NO_OF_MASTERS-1:0] req;
  logic [NO_OF_MASTERS-1:0] acc;
  logic                     s_pready;
  logic [NO_OF_MASTERS-1:0] grant;
  logic [OWNER_W-1:0]       owner;
  logic                     busy;
  logic                     abort_resp;
  logic                     timeout_err;
  logic                     proto_err;

  modport slave (
    input  req, acc, s_pready,
    output grant, owner, busy, abort_resp, timeout_err, proto_err
  );

  modport master (
    output req, acc, s_pready,
    input  grant, owner, busy, abort_resp, timeout_err, proto_err
  );
endinterface

// File: rtl/apb_wrr_arbiter.sv
// Arbitrates one shared APB slave between several masters using fixed priority
// or weighted round-robin, with an ACCESS wait timeout and abandon detection.
module apb_wrr_arbiter #(
  parameter int NO_OF_MASTERS  = 2,
  parameter int WEIGHT_W       = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                              pclk,
  input  logic                              preset_n,
  input  logic                              cfg_fixed_prio,
  input  logic [NO_OF_MASTERS*WEIGHT_W-1:0] cfg_weight,
  apb_wrr_arbiter_if.slave                  bus
);
  localparam int OW = (NO_OF_MASTERS > 1) ? $clog2(NO_OF_MASTERS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WAIT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] WAIT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_OWNED, S_ABORT} state_t;

  state_t              r_state, w_state_next;
  logic [OW-1:0]       r_owner, w_owner_next;
  logic [OW-1:0]       r_rr_ptr, w_rr_ptr_next;
  logic [CW-1:0]       r_wait_cnt, w_wait_cnt_next;
  logic [WEIGHT_W-1:0] r_used [NO_OF_MASTERS];
  logic [WEIGHT_W-1:0] w_used_next [NO_OF_MASTERS];

  logic [OW-1:0]            w_fix_idx, w_wrr_idx, w_sel_idx;
  logic                     w_found, w_any_req, w_proto;
  int                       w_scan;
  logic [WEIGHT_W-1:0]      w_weight;
  logic [WEIGHT_W:0]        w_eff, w_used_inc;
  logic [NO_OF_MASTERS-1:0] w_grant;

  // Candidate winners for both policies; the scan starts at rr_ptr and wraps.
  always_comb begin
    w_fix_idx = '0;
    for (int i = NO_OF_MASTERS - 1; i >= 0; i--) begin
      if (bus.req[i]) w_fix_idx = OW'(i);
    end
    w_wrr_idx = '0;
    w_found   = 1'b0;
    w_scan    = 0;
    for (int k = 0; k < NO_OF_MASTERS; k++) begin
      w_scan = int'(r_rr_ptr) + k;
      if (w_scan >= NO_OF_MASTERS) w_scan = w_scan - NO_OF_MASTERS;
      if (!w_found && bus.req[OW'(w_scan)]) begin
        w_found   = 1'b1;
        w_wrr_idx = OW'(w_scan);
      end
    end
  end

  assign w_any_req  = |bus.req;
  assign w_sel_idx  = cfg_fixed_prio ? w_fix_idx : w_wrr_idx;
  assign w_weight   = cfg_weight[int'(w_wrr_idx)*WEIGHT_W +: WEIGHT_W];
  assign w_eff      = (w_weight == '0) ? (WEIGHT_W+1)'(1) : {1'b0, w_weight};
  assign w_used_inc = {1'b0, r_used[w_wrr_idx]} + (WEIGHT_W+1)'(1);

  always_comb begin
    w_state_next    = r_state;
    w_owner_next    = r_owner;
    w_rr_ptr_next   = r_rr_ptr;
    w_wait_cnt_next = r_wait_cnt;
    w_grant         = '0;
    w_proto         = 1'b0;
    for (int i = 0; i < NO_OF_MASTERS; i++) w_used_next[i] = r_used[i];

    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          for (int i = 0; i < NO_OF_MASTERS; i++) begin
            if (OW'(i) == w_sel_idx) w_grant[i] = 1'b1;
          end
          w_owner_next    = w_sel_idx;
          w_wait_cnt_next = '0;
          w_state_next    = S_OWNED;
          if (!cfg_fixed_prio) begin
            // A master skipped over at rr_ptr forfeits the rest of its burst.
            if (w_wrr_idx != r_rr_ptr) w_used_next[r_rr_ptr] = '0;
            // >= so a weight lowered below the running count ends the burst.
            if (w_used_inc >= w_eff) begin
              w_used_next[w_wrr_idx] = '0;
              w_rr_ptr_next = (int'(w_wrr_idx) == NO_OF_MASTERS - 1) ? '0 : w_wrr_idx + OW'(1);
            end else begin
              w_used_next[w_wrr_idx] = w_used_inc[WEIGHT_W-1:0];
              w_rr_ptr_next          = w_wrr_idx;
            end
          end
        end
      end
      S_OWNED: begin
        if (bus.acc[r_owner]) begin
          if (bus.s_pready) begin
            w_state_next = S_IDLE;
          end else begin
            if (r_wait_cnt != WAIT_MAX) w_wait_cnt_next = r_wait_cnt + CW'(1);
            if (TIMEOUT_CYCLES != 0 && r_wait_cnt == WAIT_LAST) w_state_next = S_ABORT;
          end
        end else if (!bus.req[r_owner]) begin
          w_state_next = S_IDLE;
          w_proto      = 1'b1;
        end
      end
      S_ABORT: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_wait_cnt <= '0;
      for (int i = 0; i < NO_OF_MASTERS; i++) r_used[i] <= '0;
    end else begin
      r_state    <= w_state_next;
      r_owner    <= w_owner_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_wait_cnt <= w_wait_cnt_next;
      for (int i = 0; i < NO_OF_MASTERS; i++) r_used[i] <= w_used_next[i];
    end
  end

  // Grant is combinational, so it is masked while reset is held.
  assign bus.grant       = preset_n ? w_grant : '0;
  assign bus.owner       = r_owner;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.abort_resp  = (r_state == S_ABORT);
  // ABORT is only reachable through a timeout and lasts one cycle.
  assign bus.timeout_err = (r_state == S_ABORT);
  assign bus.proto_err   = w_proto;
endmodule
